ifetch_stage: RTL and testbench

IFETCH_STAGE -- requirements
Module: ifetch_stage

---
 rtl/ifetch_stage.sv | 125 ++++++++++++
 tb/tb_ifetch_stage.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: PC sequencing, in-order response tracking, a 2-entry {instr, pc} FIFO and redirect flush.
// Optional FETCH_MISALIGN_CHK_EN adds a sticky misalign_err output for misaligned redirect targets.
module ifetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic        misalign_err
`endif
);

    logic [31:0] r_pc;
    logic [31:0] r_rsp_pc;
    logic [1:0]  r_out_cnt;
    logic [1:0]  r_drop_cnt;
    logic [31:0] r_fifo_instr [2];
    logic [31:0] r_fifo_pc    [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_fifo_cnt;

    logic [31:0] w_redir_pc;
    logic        w_fetch_hold;
    logic [2:0]  w_inflight;
    logic        w_req_fire;
    logic        w_rsp_fire;
    logic        w_rsp_drop;
    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_out_after_rsp;

`ifdef FETCH_MISALIGN_CHK_EN
    logic r_misalign;

    assign w_redir_pc   = redirect_pc;
    assign w_fetch_hold = r_misalign;
    assign misalign_err = r_misalign;

    // Sticky until the next redirect; an aligned target clears it and fetch resumes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else if (redirect_valid) begin
            r_misalign <= (redirect_pc[1:0] != 2'b00);
        end
    end
`else
    assign w_redir_pc   = redirect_pc & 32'hFFFF_FFFC;
    assign w_fetch_hold = 1'b0;
`endif

    // Every issued request reserves a FIFO slot, so the FIFO can never overflow.
    assign w_inflight     = {1'b0, r_out_cnt} + {1'b0, r_fifo_cnt};
    assign imem_req_valid = rst_n & ~redirect_valid & ~w_fetch_hold & (w_inflight < 3'd2);
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;

    assign w_rsp_fire      = imem_rsp_valid & (r_out_cnt != 2'd0);
    assign w_rsp_drop      = (r_drop_cnt != 2'd0);
    assign w_push          = w_rsp_fire & ~w_rsp_drop & ~redirect_valid;
    assign w_out_after_rsp = r_out_cnt - {1'b0, w_rsp_fire};

    assign if_valid = (r_fifo_cnt != 2'd0) & ~redirect_valid;
    assign if_instr = r_fifo_instr[r_rd_ptr];
    assign if_pc    = r_fifo_pc[r_rd_ptr];
    assign w_pop    = if_valid & if_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_out_cnt  <= 2'd0;
            r_drop_cnt <= 2'd0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_fifo_cnt <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_instr[i] <= 32'd0;
                r_fifo_pc[i]    <= 32'd0;
            end
        end else begin
            r_out_cnt <= w_out_after_rsp + {1'b0, w_req_fire};
            if (redirect_valid) begin
                // Requests still in flight after this cycle return stale words and must be dropped.
                r_pc       <= w_redir_pc;
                r_rsp_pc   <= w_redir_pc;
                r_drop_cnt <= w_out_after_rsp;
                r_rd_ptr   <= 1'b0;
                r_wr_ptr   <= 1'b0;
                r_fifo_cnt <= 2'd0;
            end else begin
                if (w_req_fire) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_rsp_fire && w_rsp_drop) begin
                    r_drop_cnt <= r_drop_cnt - 2'd1;
                end
                if (w_push) begin
                    r_fifo_instr[r_wr_ptr] <= imem_rsp_data;
                    r_fifo_pc[r_wr_ptr]    <= r_rsp_pc;
                    r_wr_ptr               <= ~r_wr_ptr;
                    r_rsp_pc               <= r_rsp_pc + 32'd4;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

endmodule

// File: tb/tb_ifetch_stage.sv
// Bench for ifetch_stage: in-order memory model with configurable latency and a scoreboard of expected {instr, pc}.
// Handshakes: a transfer happens in a cycle where valid and ready are both high at the rising edge.
module tb_ifetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        misalign_err;
`endif

    ifetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_t;

    logic [63:0] exp_q[$];
    mem_t        mem_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          fire_cnt = 0;
    logic        hold_pending = 1'b0;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;

    // Clock and reset-cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic exp_push(input logic [31:0] pc);
        exp_q.push_back({mem_f(pc), pc});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let decode consume until the scoreboard empties, then stall decode again.
    task automatic drain(input string nm);
        bit done = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: %0d entries never delivered", nm, exp_q.size());
            exp_q.delete();
        end
        step();
        if_ready = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = pc;
    endtask

    // Instruction memory: in order, responds lat cycles after acceptance, shares rst_n.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem_q.delete();
                imem_rsp_valid = 1'b0;
            end else begin
                if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_f(mem_q[0].addr);
                    void'(mem_q.pop_front());
                end else begin
                    imem_rsp_valid = 1'b0;
                end
                if (imem_req_valid && imem_req_ready) begin
                    mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
                    fire_cnt++;
                end
            end
        end
    end

    // Monitor: every accepted instruction is compared with the scoreboard head; stalled outputs must hold.
    initial forever begin
        logic [63:0] e;
        @(negedge clk);
        if (rst_n && if_valid) begin
            if (hold_pending) begin
                chk("hold_pc", if_pc, hold_pc);
                chk("hold_instr", if_instr, hold_instr);
            end
            if (if_ready) begin
                hold_pending = 1'b0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_instr: got pc %h instr %h, none expected", if_pc, if_instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", if_pc, e[31:0]);
                    chk("sb_instr", if_instr, e[63:32]);
                end
            end else begin
                hold_pending = 1'b1;
                hold_pc      = if_pc;
                hold_instr   = if_instr;
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    initial begin
        int f0;
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        if_ready       = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
`endif

        // Streaming after reset release, 2-cycle latency to first instruction
        for (int i = 0; i < 8; i++) exp_push(RESET_PC + 32'(i * 4));
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("first_req_addr", imem_req_addr, RESET_PC);
        chk("lat_c0_if_valid", {31'd0, if_valid}, 32'd0);
        @(negedge clk);
        chk("lat_c1_if_valid", {31'd0, if_valid}, 32'd0);
        @(negedge clk);
        chk("lat_c2_if_valid", {31'd0, if_valid}, 32'd1);
        chk("lat_c2_if_pc", if_pc, RESET_PC);
        drain("stream");

        // Decode stalled for 5 cycles: FIFO fills, head holds at 0x20
        f0 = fire_cnt;
        repeat (5) @(negedge clk);
        #1;
        chk("stall_if_valid", {31'd0, if_valid}, 32'd1);
        chk("stall_head_pc", if_pc, 32'h20);
        chk("stall_head_instr", if_instr, mem_f(32'h20));
        chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("stall_reqs_le2", {31'd0, (fire_cnt - f0) <= 2}, 32'd1);
        for (int i = 0; i < 4; i++) exp_push(32'h20 + 32'(i * 4));
        step();
        if_ready = 1'b1;
        drain("stall_release");
        repeat (4) step();

        // Redirect with a full FIFO, then a second redirect with 2 requests in flight
        lat = 4;
        redirect(32'h40);
        @(negedge clk);
        chk("redir_if_valid", {31'd0, if_valid}, 32'd0);
        chk("redir_req_valid", {31'd0, imem_req_valid}, 32'd0);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir1_req_addr", imem_req_addr, 32'h40);
        chk("redir1_req_valid", {31'd0, imem_req_valid}, 32'd1);
        step();
        redirect(32'h100);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir2_req_addr", imem_req_addr, 32'h100);
        chk("redir2_req_valid", {31'd0, imem_req_valid}, 32'd0);
        exp_push(32'h100);
        exp_push(32'h104);
        step();
        if_ready = 1'b1;
        drain("redirect_drop");

        // Address wrap at the top of the address space
        lat = 1;
        redirect(32'hFFFF_FFF8);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFF8);
        exp_push(32'hFFFF_FFF8);
        exp_push(32'hFFFF_FFFC);
        exp_push(32'h0000_0000);
        exp_push(32'h0000_0004);
        step();
        if_ready = 1'b1;
        drain("wrap");

`ifdef FETCH_MISALIGN_CHK_EN
        // Misaligned redirect stops fetch until an aligned redirect
        redirect(32'h102);
        step();
        redirect_valid = 1'b0;
        f0 = fire_cnt;
        @(negedge clk);
        chk("mis_err_set", {31'd0, misalign_err}, 32'd1);
        repeat (5) @(negedge clk);
        chk("mis_no_reqs", 32'(fire_cnt - f0), 32'd0);
        chk("mis_req_valid", {31'd0, imem_req_valid}, 32'd0);
        redirect(32'h200);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("mis_err_clear", {31'd0, misalign_err}, 32'd0);
        chk("mis_resume_addr", imem_req_addr, 32'h200);
        exp_push(32'h200);
        exp_push(32'h204);
`else
        // Low two bits of the redirect target are ignored
        redirect(32'h102);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("align_req_addr", imem_req_addr, 32'h100);
        exp_push(32'h100);
        exp_push(32'h104);
`endif
        step();
        if_ready = 1'b1;
        drain("after_misalign");
        repeat (3) step();

        // One-cycle reset mid-stream
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        exp_push(RESET_PC);
        exp_push(RESET_PC + 32'd4);
        @(negedge clk);
        chk("midrst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("midrst_if_pc", if_pc, 32'd0);
        chk("midrst_if_instr", if_instr, 32'd0);
        chk("midrst_req_addr", imem_req_addr, RESET_PC);
        chk("midrst_req_valid_after", {31'd0, imem_req_valid}, 32'd1);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("midrst_misalign", {31'd0, misalign_err}, 32'd0);
`endif
        step();
        if_ready = 1'b1;
        drain("restart");
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
